// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM encoding and access legality check for the LSU
package lsu_pkg;

   localparam int WORD_BYTES = 4;
   localparam int LANE_W     = $clog2(WORD_BYTES);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_RD,
      S_LD_DATA,
      S_RMW_RD,
      S_RMW_MERGE,
      S_WR
   } state_t;

   // funct3[1:0] encodes the access size for both loads and stores
   function automatic logic is_illegal(input logic            write,
                                       input logic [2:0]      funct3,
                                       input logic [LANE_W-1:0] lane);
      logic bad_f3;
      logic misaligned;
      if (write)
         bad_f3 = (funct3 > F3_W);
      else
         bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      misaligned = ((funct3[1:0] == 2'b01) && lane[0]) ||
                   ((funct3[1:0] == 2'b10) && (lane != '0));
      return bad_f3 | misaligned;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian load lane extract/extend and store lane merge
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_word,
   input  logic [15:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_merge_data
);

   logic [15:0] w_shifted;

   always_comb begin
      w_shifted = 16'(i_word >> {i_addr_lo, 3'b000});
      case (i_funct3)
         F3_B:    o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
         F3_H:    o_load_data = {{16{w_shifted[15]}}, w_shifted};
         F3_BU:   o_load_data = {24'd0, w_shifted[7:0]};
         F3_HU:   o_load_data = {16'd0, w_shifted};
         default: o_load_data = i_word;
      endcase

      o_merge_data = i_word;
      if (i_funct3[1:0] == 2'b00)
         o_merge_data[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      else if (i_funct3[1:0] == 2'b01)
         o_merge_data[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata;
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store initiator for a word-wide memory
// Sub-word stores are read-modify-write since the memory has no byte enables.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter  int MEMSIZE = 32 * 1024,
   parameter  int XLEN    = 32,
   localparam int ADDR_W  = $clog2(MEMSIZE)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [XLEN-1:0]   resp_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read_en,
   output logic              mem_write_en,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata
);

   state_t            r_state;
   logic [2:0]        r_funct3;
   logic [LANE_W-1:0] r_addr_lo;
   logic [15:0]       r_wdata_lo;

   logic [31:0]       w_load_data;
   logic [31:0]       w_merge_data;
   logic              w_illegal;
   logic              w_unused_addr;

   // address bits above the memory size alias onto the same words
   assign w_unused_addr = ^req_addr[XLEN-1:ADDR_W];
   assign w_illegal     = is_illegal(req_write, req_funct3, req_addr[LANE_W-1:0]);
   assign req_ready     = (r_state == S_IDLE);

   lsu_lane_align u_lane_align (
      .i_funct3     (r_funct3),
      .i_addr_lo    (r_addr_lo),
      .i_word       (mem_rdata),
      .i_wdata      (r_wdata_lo),
      .o_load_data  (w_load_data),
      .o_merge_data (w_merge_data)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_funct3     <= '0;
         r_addr_lo    <= '0;
         r_wdata_lo   <= '0;
         resp_valid   <= 1'b0;
         resp_err     <= 1'b0;
         resp_rdata   <= '0;
         mem_address  <= '0;
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
         mem_wdata    <= '0;
      end else begin
         resp_valid   <= 1'b0;
         resp_err     <= 1'b0;
         resp_rdata   <= '0;
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  if (w_illegal) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else begin
                     r_funct3    <= req_funct3;
                     r_addr_lo   <= req_addr[LANE_W-1:0];
                     r_wdata_lo  <= req_wdata[15:0];
                     mem_address <= {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                     if (!req_write) begin
                        r_state     <= S_LD_RD;
                        mem_read_en <= 1'b1;
                     end else if (req_funct3 == F3_W) begin
                        r_state      <= S_WR;
                        mem_write_en <= 1'b1;
                        mem_wdata    <= req_wdata;
                     end else begin
                        r_state     <= S_RMW_RD;
                        mem_read_en <= 1'b1;
                     end
                  end
               end
            end
            S_LD_RD:   r_state <= S_LD_DATA;
            S_LD_DATA: begin
               resp_valid <= 1'b1;
               resp_rdata <= w_load_data;
               r_state    <= S_IDLE;
            end
            S_RMW_RD:  r_state <= S_RMW_MERGE;
            S_RMW_MERGE: begin
               mem_wdata    <= w_merge_data;
               mem_write_en <= 1'b1;
               r_state      <= S_WR;
            end
            S_WR: begin
               resp_valid <= 1'b1;
               r_state    <= S_IDLE;
            end
            default:   r_state <= S_IDLE;
         endcase
      end
   end

endmodule
